// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared widths, state encodings and limits for the LPC I/O dispatcher
// Purpose: common definitions imported by lpc_win_decode and lpc_io_dispatch.
// Ports: none (package).
package lpc_pkg;

  localparam int LPC_ADDR_W = 16;
  localparam int LPC_DATA_W = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    ACCESS   = ST_ACCESS,
    WAIT_END = ST_WAIT_END
  } lpc_state_e;

  localparam logic [LPC_DATA_W-1:0] MISS_MAX = 8'hFF;

endpackage

// File: rtl/lpc_win_decode.sv
// rtl/lpc_win_decode.sv - base/mask window compare with lowest-index-wins priority
// Purpose: combinational address decode for NUM_TGT backend targets.
// Ports:
//   addr       in  LPC_ADDR_W  I/O address being decoded
//   tgt_en     in  NUM_TGT     per-target runtime enable
//   hit_onehot out NUM_TGT     one-hot winning target, 0 when nothing matches
module lpc_win_decode
  import lpc_pkg::*;
#(
  parameter int                          NUM_TGT  = 4,
  parameter logic [NUM_TGT*16-1:0]       TGT_BASE = {16'h0400, 16'h03F8, 16'h0060, 16'h0080},
  parameter logic [NUM_TGT*16-1:0]       TGT_MASK = {16'hFF00, 16'hFFF8, 16'hFFFB, 16'hFFFF}
) (
  input  logic [LPC_ADDR_W-1:0] addr,
  input  logic [NUM_TGT-1:0]    tgt_en,
  output logic [NUM_TGT-1:0]    hit_onehot
);

  logic [NUM_TGT-1:0] hit_raw;
  logic               found;

  always_comb begin
    hit_raw = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      // A mask bit of 1 means that address bit must equal the base bit.
      hit_raw[i] = tgt_en[i] &
                   (((addr ^ TGT_BASE[LPC_ADDR_W*i +: LPC_ADDR_W]) &
                     TGT_MASK[LPC_ADDR_W*i +: LPC_ADDR_W]) == '0);
    end
  end

  // Overlapping windows resolve to the lowest index.
  always_comb begin
    hit_onehot = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (hit_raw[i] && !found) begin
        hit_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpc_io_dispatch.sv
// rtl/lpc_io_dispatch.sv - LPC I/O cycle claim, target strobe sequencing and read-data return
// Purpose: decode each LPC I/O cycle against the target windows, claim it in C0,
//   fire a one-cycle read or write strobe in C1 and hold the captured read data on din.
// Ports:
//   lclk, lreset_n            clock, async active-low reset
//   lpc_en, lpc_addr          cycle valid and I/O address from the LPC peripheral
//   io_rden_sm, io_wren_sm    read / write cycle flags
//   lpc_data_in               write data
//   addr_hit, din             claim and read data back to the peripheral
//   tgt_en                    per-target enable
//   tgt_sel, tgt_addr,
//   tgt_wdata, tgt_rd, tgt_wr shared backend bus
//   tgt_rdata                 per-target combinational read data
//   miss_cnt                  saturating count of unclaimed cycles
module lpc_io_dispatch
  import lpc_pkg::*;
#(
  parameter int                    NUM_TGT  = 4,
  parameter logic [NUM_TGT*16-1:0] TGT_BASE = {16'h0400, 16'h03F8, 16'h0060, 16'h0080},
  parameter logic [NUM_TGT*16-1:0] TGT_MASK = {16'hFF00, 16'hFFF8, 16'hFFFB, 16'hFFFF}
) (
  input  logic                    lclk,
  input  logic                    lreset_n,
  input  logic                    lpc_en,
  input  logic [LPC_ADDR_W-1:0]   lpc_addr,
  input  logic                    io_rden_sm,
  input  logic                    io_wren_sm,
  input  logic [LPC_DATA_W-1:0]   lpc_data_in,
  output logic                    addr_hit,
  output logic [LPC_DATA_W-1:0]   din,
  input  logic [NUM_TGT-1:0]      tgt_en,
  output logic [NUM_TGT-1:0]      tgt_sel,
  output logic [LPC_ADDR_W-1:0]   tgt_addr,
  output logic [LPC_DATA_W-1:0]   tgt_wdata,
  output logic                    tgt_rd,
  output logic                    tgt_wr,
  input  logic [NUM_TGT*8-1:0]    tgt_rdata,
  output logic [LPC_DATA_W-1:0]   miss_cnt
);

  lpc_state_e              state_q, state_d;
  logic [NUM_TGT-1:0]      hit_d, hit_q;
  logic [NUM_TGT-1:0]      tgt_sel_q, tgt_sel_d;
  logic [LPC_ADDR_W-1:0]   tgt_addr_q, tgt_addr_d;
  logic [LPC_DATA_W-1:0]   tgt_wdata_q, tgt_wdata_d;
  logic [LPC_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    tgt_rd_q, tgt_rd_d;
  logic                    tgt_wr_q, tgt_wr_d;
  logic [LPC_DATA_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [LPC_DATA_W-1:0]   sel_rdata;

  lpc_win_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr       (lpc_addr),
    .tgt_en     (tgt_en),
    .hit_onehot (hit_d)
  );

  // hit_q is one-hot (or zero), so OR-ing the gated bytes is a clean mux.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (hit_q[i]) begin
        sel_rdata = sel_rdata | tgt_rdata[8*i +: 8];
      end
    end
  end

  // The address settles a cycle before lpc_en rises, so the registered decode
  // is already valid in C0 and the claim needs no further pipeline stage.
  assign addr_hit = (state_q == IDLE) & lpc_en & (|hit_q);

  always_comb begin
    state_d     = state_q;
    tgt_sel_d   = tgt_sel_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    rdata_d     = rdata_q;
    miss_cnt_d  = miss_cnt_q;
    tgt_rd_d    = 1'b0;
    tgt_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lpc_en) begin
          if (|hit_q) begin
            tgt_sel_d   = hit_q;
            tgt_addr_d  = lpc_addr;
            tgt_wdata_d = lpc_data_in;
            // Capture before the strobe so read side effects cannot alter din.
            rdata_d     = sel_rdata;
            tgt_rd_d    = io_rden_sm;
            tgt_wr_d    = io_wren_sm & ~io_rden_sm;
            state_d     = ACCESS;
          end else begin
            if (miss_cnt_q != MISS_MAX) begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
            state_d = WAIT_END;
          end
        end
      end
      ACCESS: begin
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (!lpc_en) begin
          state_d   = IDLE;
          tgt_sel_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        tgt_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q     <= IDLE;
      hit_q       <= '0;
      tgt_sel_q   <= '0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      rdata_q     <= '0;
      tgt_rd_q    <= 1'b0;
      tgt_wr_q    <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      tgt_sel_q   <= tgt_sel_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      rdata_q     <= rdata_d;
      tgt_rd_q    <= tgt_rd_d;
      tgt_wr_q    <= tgt_wr_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign din       = rdata_q;
  assign tgt_sel   = tgt_sel_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;
  assign tgt_rd    = tgt_rd_q;
  assign tgt_wr    = tgt_wr_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/lpc_io_dispatch.md
Name: lpc_io_dispatch

Overview:
- Backend controller for the LPC I/O peripheral.
- Decodes each completed LPC I/O cycle (lpc_en/lpc_addr/io_rden_sm/io_wren_sm) against NUM_TGT base/mask windows, returns addr_hit in time for TAR sampling, and shares the single backend bus between targets.
- Sequences one-cycle read/write strobes to the selected target and presents its read data on din for both nibble phases.
- Counts unclaimed cycles for debug.

Parameters:
NUM_TGT, 4, number of backend targets; index 0 is highest priority on overlapping windows
TGT_BASE, {16'h0400,16'h03F8,16'h0060,16'h0080}, packed NUM_TGT*16 base addresses, target i at [16i+15:16i]
TGT_MASK, {16'hFF00,16'hFFF8,16'hFFFB,16'hFFFF}, packed NUM_TGT*16 compare masks; 1 = bit compared

Ports:
lclk  in  1  LPC clock
lreset_n  in  1  async reset, active low
lpc_en  in  1  cycle-valid from LPC peripheral
lpc_addr  in  16  I/O address
io_rden_sm  in  1  read cycle flag
io_wren_sm  in  1  write cycle flag
lpc_data_in  in  8  write data
addr_hit  out  1  claim to LPC peripheral
din  out  8  read data to LPC peripheral
tgt_en  in  NUM_TGT  runtime per-target enable
tgt_sel  out  NUM_TGT  one-hot selected target
tgt_addr  out  16  registered cycle address
tgt_wdata  out  8  registered write data
tgt_rd  out  1  read side-effect strobe, one cycle
tgt_wr  out  1  write strobe, one cycle
tgt_rdata  in  NUM_TGT*8  combinational read data per target
miss_cnt  out  8  saturating count of unclaimed cycles

Behaviour:
- Reset (async, any state): state=IDLE. addr_hit, din, tgt_sel, tgt_addr, tgt_wdata, tgt_rd, tgt_wr, miss_cnt all 0.
- hit_q: registered every clock, bit i = tgt_en[i] & ((lpc_addr ^ base_i) & mask_i)==0. Priority-reduced to one-hot (lowest index wins).
- Timing: lpc_addr is complete one cycle before lpc_en rises, so hit_q is valid in C0, the first lpc_en=1 cycle.
- addr_hit = (state==IDLE) & lpc_en & |hit_q. It is combinational from registers, so it is valid throughout C0.
- IDLE:
  - On C0 (lpc_en=1 while in IDLE) with hit: latch tgt_sel=hit_q, tgt_addr=lpc_addr, tgt_wdata=lpc_data_in, rdata_q = tgt_rdata of selected target; go ACCESS.
  - On C0 with no hit: miss_cnt+1 (saturates at 8'hFF); go WAIT_END.
- ACCESS (C1):
  - tgt_rd=1 if io_rden_sm, else tgt_wr=1 if io_wren_sm. Exactly one cycle.
  - If both flags are set, read wins and tgt_wr stays 0.
  - Go WAIT_END.
- WAIT_END: strobes 0; stay until lpc_en=0, then IDLE and tgt_sel=0. tgt_addr/tgt_wdata hold their last values.
- din = rdata_q, held from C1 until the next claim. This covers the peripheral's low-nibble sample (end C1) and high-nibble sample (end C2). Target side effects from tgt_rd therefore cannot corrupt returned data.
- A cycle claimed at end of C0 is committed: the strobe fires in C1 even if the host aborts via lframe_n.
- lpc_en must fall before a new cycle is decoded. Back-to-back cycles need the one-cycle gap the peripheral already provides.
- Latency: claim 0 cycles after lpc_en rise; strobe 1 cycle; read data valid 1 cycle.

Decomposition:
- Package lpc_pkg: LPC_ADDR_W=16, LPC_DATA_W=8, state encodings (IDLE, ACCESS, WAIT_END as 2-bit localparams), MISS_MAX=8'hFF.
- Sub-module lpc_win_decode: combinational base/mask compare plus priority one-hot encoder, parameterised by NUM_TGT. The dispatcher registers its output.

Test Plan:
- Write 0x0080 data 8'h5A, all enabled -> addr_hit=1 in C0; tgt_sel=4'b0001, tgt_wr=1 for exactly C1 with tgt_wdata=8'h5A, tgt_addr=16'h0080; tgt_rd=0.
- Read 0x0064, target1 rdata=8'hC3 -> addr_hit=1; din=8'hC3 during C1 and C2 even though target1 changes rdata to 8'h00 after tgt_rd in C1; tgt_sel=4'b0010.
- Read 0x03FD with tgt_en=4'b1011 -> addr_hit=0, no strobes, miss_cnt 0->1. Then set tgt_en=4'b1111, repeat -> tgt_sel=4'b0100, din=target2 data.
- 300 unclaimed cycles to 0x1234 -> miss_cnt stops at 8'hFF.
- Overlap: override TGT_BASE so targets 0 and 3 both decode 0x0480; access 0x0480 -> tgt_sel=4'b0001 only.
- Assert lreset_n low during ACCESS of a write -> tgt_wr drops immediately, all outputs 0; after release, the next read to 0x0080 is claimed normally.
